p2s_serial_sched: RTL

- Arbitrates one shared parallel-to-serial shifter between two word sources: a 24-bit requester and a 16-bit requester.
- Latches the granted word and generates the serial clock, data and frame-sync lines toward the downstream serial receiver.
- Enforces an inter-frame gap.
- Sits between the acquisition/control logic producing parallel words and the serial link pins.

---
 rtl/p2s_serial_sched_if.sv | 26 ++
 rtl/p2s_serial_sched.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/p2s_serial_sched_if.sv
// Bundle of request/ack handshakes and serial-link outputs for p2s_serial_sched.
// The master side drives words and requests; the slave side (the scheduler) drives the link.
interface p2s_serial_sched_if;
  logic        req24;
  logic [23:0] pdata24;
  logic        ack24;
  logic        req16;
  logic [15:0] pdata16;
  logic        ack16;
  logic        sclk;
  logic        sdata;
  logic        sync_n;
  logic        frame_sel;
  logic        busy;
  logic        done;

  modport master (
    output req24, pdata24, req16, pdata16,
    input  ack24, ack16, sclk, sdata, sync_n, frame_sel, busy, done
  );

  modport slave (
    input  req24, pdata24, req16, pdata16,
    output ack24, ack16, sclk, sdata, sync_n, frame_sel, busy, done
  );
endinterface

// File: rtl/p2s_serial_sched.sv
// Round-robin scheduler sharing one serial shifter between a 24-bit and a 16-bit source.
// Define P2S_PARITY_EN to append an odd-parity bit after the LSB of every frame.
module p2s_serial_sched #(
  parameter int CLK_DIV  = 4,
  parameter int GAP_BITS = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  p2s_serial_sched_if.slave   bus
);

`ifdef P2S_PARITY_EN
  localparam int SHW = 25;
`else
  localparam int SHW = 24;
`endif
  localparam int GAP_LEN = GAP_BITS * 2 * CLK_DIV;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GAP_W   = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_LEN - 1);
  localparam logic [4:0]       CNT24    = 5'(SHW - 1);
  localparam logic [4:0]       CNT16    = 5'(SHW - 9);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_e;

  // 16-bit words sit left-justified so both sources shift out of the same MSB.
  function automatic logic [SHW-1:0] load24(input logic [23:0] w);
`ifdef P2S_PARITY_EN
    return {w, ~^w};
`else
    return w;
`endif
  endfunction

  function automatic logic [SHW-1:0] load16(input logic [15:0] w);
`ifdef P2S_PARITY_EN
    return {w, ~^w, 8'h00};
`else
    return {w, 8'h00};
`endif
  endfunction

  state_e           state_q, state_d;
  logic [SHW-1:0]   shreg_q, shreg_d;
  logic [4:0]       bitcnt_q, bitcnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             sclk_q, sclk_d;
  logic             sdata_q, sdata_d;
  logic             sync_n_q, sync_n_d;
  logic             frame_sel_q, frame_sel_d;
  logic             ack24_q, ack24_d;
  logic             ack16_q, ack16_d;
  logic             done_q, done_d;
  logic             last24_q, last24_d;
  logic             grant24;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      bitcnt_q    <= '0;
      div_q       <= '0;
      gap_q       <= '0;
      sclk_q      <= 1'b0;
      sdata_q     <= 1'b0;
      sync_n_q    <= 1'b1;
      frame_sel_q <= 1'b0;
      ack24_q     <= 1'b0;
      ack16_q     <= 1'b0;
      done_q      <= 1'b0;
      last24_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bitcnt_q    <= bitcnt_d;
      div_q       <= div_d;
      gap_q       <= gap_d;
      sclk_q      <= sclk_d;
      sdata_q     <= sdata_d;
      sync_n_q    <= sync_n_d;
      frame_sel_q <= frame_sel_d;
      ack24_q     <= ack24_d;
      ack16_q     <= ack16_d;
      done_q      <= done_d;
      last24_q    <= last24_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bitcnt_d    = bitcnt_q;
    div_d       = div_q;
    gap_d       = gap_q;
    sclk_d      = sclk_q;
    sdata_d     = sdata_q;
    sync_n_d    = sync_n_q;
    frame_sel_d = frame_sel_q;
    last24_d    = last24_q;
    ack24_d     = 1'b0;
    ack16_d     = 1'b0;
    done_d      = 1'b0;
    grant24     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.req24 || bus.req16) begin
          // On a tie the source that was not served last wins.
          grant24 = bus.req24 && (!bus.req16 || !last24_q);
          if (grant24) begin
            shreg_d  = load24(bus.pdata24);
            bitcnt_d = CNT24;
          end else begin
            shreg_d  = load16(bus.pdata16);
            bitcnt_d = CNT16;
          end
          frame_sel_d = grant24;
          last24_d    = grant24;
          ack24_d     = grant24;
          ack16_d     = !grant24;
          sync_n_d    = 1'b0;
          sdata_d     = shreg_d[SHW-1];
          sclk_d      = 1'b0;
          div_d       = '0;
          state_d     = SHIFT;
        end
      end

      SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            if (bitcnt_q != 5'd0) begin
              shreg_d  = {shreg_q[SHW-2:0], 1'b0};
              sdata_d  = shreg_q[SHW-2];
              bitcnt_d = bitcnt_q - 5'd1;
            end else begin
              sync_n_d = 1'b1;
              sdata_d  = 1'b0;
              done_d   = 1'b1;
              gap_d    = '0;
              state_d  = (GAP_LEN == 0) ? IDLE : GAP;
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.ack24     = ack24_q;
  assign bus.ack16     = ack16_q;
  assign bus.sclk      = sclk_q;
  assign bus.sdata     = sdata_q;
  assign bus.sync_n    = sync_n_q;
  assign bus.frame_sel = frame_sel_q;
  assign bus.done      = done_q;
  assign bus.busy      = (state_q != IDLE);

endmodule
